// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// The lookup is combinational and read-before-write. Training comes from EX.
module branch_predictor #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [31:0]        branch_cnt_q, branch_cnt_d;
  logic [31:0]        mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx_f, upd_idx;
  logic [TAG_W-1:0] tag_f, upd_tag;
  logic             hit_f, upd_hit, upd_fire;

  assign idx_f   = pc_f[IDX_W+1:2];
  assign tag_f   = pc_f[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  assign hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_fire = upd_en && !rst;

  // Outputs are forced to the fall-through, no-flush values while reset is held.
  assign pred_taken  = !rst && hit_f && ctr_q[idx_f][1];
  assign pred_target = pred_taken ? target_q[idx_f] : (pc_f + 32'd4);

  assign mispredict  = upd_fire &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : (upd_pc + 32'd4);

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    valid_d       = valid_q;
    ctr_d         = ctr_q;
    tag_d         = tag_q;
    target_d      = target_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_fire) begin
      branch_cnt_d  = branch_cnt_q + 32'd1;
      mispred_cnt_d = mispred_cnt_q + {31'd0, mispredict};
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // A taken miss evicts whatever aliases onto this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag and target storage carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed test-plan sequence followed by randomized traffic,
// checked against an entry-level behavioural model of the BTB.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks   = 0;
  int failures = 0;

  bit          mValid  [ENTRIES];
  int unsigned mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  int unsigned mBranches;
  int unsigned mMispreds;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic int entryOf(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tagOf(logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit modelHit(logic [31:0] pc);
    return mValid[entryOf(pc)] && (mTag[entryOf(pc)] == tagOf(pc));
  endfunction

  function automatic bit modelTaken(logic [31:0] pc);
    return modelHit(pc) && (mCtr[entryOf(pc)] >= 2);
  endfunction

  function automatic logic [31:0] modelTarget(logic [31:0] pc);
    return modelTaken(pc) ? mTarget[entryOf(pc)] : pc + 32'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 1;
    end
    mBranches = 0;
    mMispreds = 0;
  endtask

  // Drive one cycle, compare against the model's pre-edge view, then commit the model.
  task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic en,
                               input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                               input logic ptk, input logic [31:0] ptgt);
    bit expMis, expTaken;
    int e;
    @(negedge clk);
    rst = r; pc_f = pc; upd_en = en; upd_pc = upc; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    expTaken = !r && modelTaken(pc);
    checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, expTaken});
    checkOutput("pred_target", pred_target, expTaken ? mTarget[entryOf(pc)] : pc + 32'd4);
    expMis = !r && en && ((ptk != tk) || (tk && ptgt != tgt));
    checkOutput("mispredict", {31'd0, mispredict}, {31'd0, expMis});
    if (expMis) checkOutput("redirect_pc", redirect_pc, tk ? tgt : upc + 32'd4);
    checkOutput("branch_cnt", branch_cnt, mBranches);
    checkOutput("mispred_cnt", mispred_cnt, mMispreds);
    if (r) begin
      modelReset();
    end else if (en) begin
      e = entryOf(upc);
      mBranches++;
      if (expMis) mMispreds++;
      if (modelHit(upc)) begin
        if (tk) begin
          mCtr[e]    = (mCtr[e] < 3) ? mCtr[e] + 1 : 3;
          mTarget[e] = tgt;
        end else begin
          mCtr[e] = (mCtr[e] > 0) ? mCtr[e] - 1 : 0;
        end
      end else if (tk) begin
        mValid[e]  = 1'b1;
        mTag[e]    = tagOf(upc);
        mTarget[e] = tgt;
        mCtr[e]    = 2;
      end
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    applyStimulus(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    applyStimulus(1'b0, pc, 1'b1, pc, tk, tgt, modelTaken(pc), modelTarget(pc));
  endtask

  function automatic logic [31:0] randPc();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] upc, tgt, ptgt;
    logic        tk, ptk;
    modelReset();

    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    checkOutput("tp1_pred_target", pred_target, 32'h104);
    checkOutput("tp1_branch_cnt", branch_cnt, 32'd0);

    applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    checkOutput("tp2_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("tp2_redirect", redirect_pc, 32'h80);
    idle(32'h100);
    checkOutput("tp2_pred_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("tp2_pred_target", pred_target, 32'h80);
    checkOutput("tp2_mispred_cnt", mispred_cnt, 32'd1);

    for (int i = 0; i < 3; i++) train(32'h100, 1'b1, 32'h80);
    train(32'h100, 1'b0, 32'h80);
    idle(32'h100);
    checkOutput("tp3_still_taken", {31'd0, pred_taken}, 32'd1);
    train(32'h100, 1'b0, 32'h80);
    idle(32'h100);
    checkOutput("tp3_now_not_taken", pred_target, 32'h104);
    train(32'h100, 1'b0, 32'h80);
    train(32'h100, 1'b0, 32'h80);
    train(32'h100, 1'b1, 32'h80);
    idle(32'h100);
    checkOutput("tp3_floor_at_zero", {31'd0, pred_taken}, 32'd0);

    train(32'h200, 1'b1, 32'h240);
    idle(32'h100);
    checkOutput("tp4_alias_evicted", pred_target, 32'h104);
    idle(32'h200);
    checkOutput("tp4_alias_target", pred_target, 32'h240);

    applyStimulus(1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h3c0, 1'b0, 32'h304);
    checkOutput("tp5_same_cycle", {31'd0, pred_taken}, 32'd0);
    idle(32'h300);
    checkOutput("tp5_next_cycle", {31'd0, pred_taken}, 32'd1);

    applyStimulus(1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h3c0, 1'b1, 32'h3c0);
    checkOutput("tp6_correct", {31'd0, mispredict}, 32'd0);
    applyStimulus(1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 32'h480, 1'b0, 32'h404);
    idle(32'h400);
    checkOutput("tp6_no_alloc", {31'd0, pred_taken}, 32'd0);
    checkOutput("tp6_cnt_cleared", branch_cnt, 32'd0);

    for (int n = 0; n < 400; n++) begin
      upc = randPc();
      tk  = 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 1) == 1) ? (upc + 32'h40) : $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ptk = modelTaken(upc); ptgt = modelTarget(upc);
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
      end
      applyStimulus(1'($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0) ? upc : randPc(),
                    1'($urandom_range(0, 3) != 0), upc, tk, tgt, ptk, ptgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
